// File: rtl/alu_pkg.sv
// Shared execute-stage definitions for the ALU and the M-extension unit.
package alu_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] FUNCT7_M = 7'b0000001;

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_dvs,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0] w_sh;
    logic [XLEN:0] w_diff;
    logic          w_ge;

    assign w_sh   = {i_rem, i_quo[XLEN-1]};
    assign w_diff = w_sh - {1'b0, i_dvs};
    // Remainder stays below the divisor, so the top bit is exactly the borrow.
    assign w_ge   = !w_diff[XLEN];
    assign o_rem  = w_ge ? w_diff[XLEN-1:0] : w_sh[XLEN-1:0];
    assign o_quo  = {i_quo[XLEN-2:0], w_ge};

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV M-extension execute unit: shift-add multiply, restoring divide.
module muldiv_unit
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TAGW    = 5,
    parameter int MUL_BPC = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rv1,
    input  logic [XLEN-1:0] rv2,
    input  logic [TAGW-1:0] tag_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [TAGW-1:0] tag_out,
    output logic            busy
);

    localparam int CW     = $clog2(XLEN);
    localparam int MUL_IT = XLEN / MUL_BPC;

    muldiv_state_e     r_state;
    muldiv_op_e        r_op;
    logic [CW-1:0]     r_cnt;
    logic [XLEN-1:0]   r_a;
    logic [2*XLEN-1:0] r_acc;
    logic              r_pneg;
    logic              r_rneg;
    logic [TAGW-1:0]   r_tag;
    logic [TAGW-1:0]   r_tag_out;
    logic [XLEN-1:0]   r_result;
    logic              r_valid;

    muldiv_op_e        w_op;
    logic              w_s1, w_s2;
    logic [XLEN-1:0]   w_m1, w_m2;
    logic              w_div0, w_ovf;
    logic [XLEN-1:0]   w_spec;

    assign w_op   = muldiv_op_e'(funct3);
    assign w_s1   = (w_op inside {MUL, MULH, MULHSU, DIV, REM}) && rv1[XLEN-1];
    assign w_s2   = (w_op inside {MUL, MULH, DIV, REM}) && rv2[XLEN-1];
    assign w_m1   = w_s1 ? -rv1 : rv1;
    assign w_m2   = w_s2 ? -rv2 : rv2;
    assign w_div0 = funct3[2] && (rv2 == '0);
    assign w_ovf  = (w_op inside {DIV, REM})
                    && (rv1 == {1'b1, {(XLEN-1){1'b0}}}) && (rv2 == '1);

    always_comb begin
        w_spec = '0;
        if (w_div0)
            w_spec = funct3[1] ? rv1 : '1;
        else if (w_ovf)
            w_spec = funct3[1] ? '0 : rv1;
    end

    logic [XLEN+MUL_BPC-1:0] w_psum;
    logic [2*XLEN-1:0]       w_mul_next;

    generate
        if (MUL_BPC == 1) begin : g_bpc1
            assign w_psum = {1'b0, r_acc[2*XLEN-1:XLEN]}
                          + {1'b0, r_a & {XLEN{r_acc[0]}}};
        end else begin : g_bpcn
            assign w_psum = {{MUL_BPC{1'b0}}, r_acc[2*XLEN-1:XLEN]}
                          + ({{MUL_BPC{1'b0}}, r_a}
                             * {{XLEN{1'b0}}, r_acc[MUL_BPC-1:0]});
        end
    endgenerate

    assign w_mul_next = {w_psum, r_acc[XLEN-1:MUL_BPC]};

    logic [XLEN-1:0] w_drem, w_dquo;

    div_step #(.XLEN(XLEN)) u_div_step (
        .i_rem (r_acc[2*XLEN-1:XLEN]),
        .i_quo (r_acc[XLEN-1:0]),
        .i_dvs (r_a),
        .o_rem (w_drem),
        .o_quo (w_dquo)
    );

    logic              w_is_div;
    logic              w_last;
    logic [2*XLEN-1:0] w_next;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo, w_rem;
    logic [XLEN-1:0]   w_fin;

    assign w_is_div = r_op[2];
    assign w_next   = w_is_div ? {w_drem, w_dquo} : w_mul_next;
    assign w_last   = w_is_div ? (r_cnt == CW'(XLEN-1)) : (r_cnt == CW'(MUL_IT-1));

    // Sign fix-up on the value the final iteration produces.
    always_comb begin
        w_prod = r_pneg ? -w_next : w_next;
        w_quo  = r_pneg ? -w_next[XLEN-1:0] : w_next[XLEN-1:0];
        w_rem  = r_rneg ? -w_next[2*XLEN-1:XLEN] : w_next[2*XLEN-1:XLEN];
        if (w_is_div)
            w_fin = r_op[1] ? w_rem : w_quo;
        else
            w_fin = (r_op == MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_op      <= MUL;
            r_cnt     <= '0;
            r_a       <= '0;
            r_acc     <= '0;
            r_pneg    <= 1'b0;
            r_rneg    <= 1'b0;
            r_tag     <= '0;
            r_tag_out <= '0;
            r_result  <= '0;
            r_valid   <= 1'b0;
        end else if (flush) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_op   <= w_op;
                        r_tag  <= tag_in;
                        r_pneg <= w_s1 ^ w_s2;
                        r_rneg <= w_s1;
                        r_cnt  <= '0;
                        r_a    <= funct3[2] ? w_m2 : w_m1;
                        r_acc  <= {{XLEN{1'b0}}, funct3[2] ? w_m1 : w_m2};
                        if (w_div0 || w_ovf) begin
                            r_result  <= w_spec;
                            r_tag_out <= tag_in;
                            r_valid   <= 1'b1;
                            r_state   <= DONE;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_acc <= w_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_cnt     <= '0;
                        r_result  <= w_fin;
                        r_tag_out <= r_tag;
                        r_valid   <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE) && !flush;
    assign busy      = (r_state != IDLE);
    assign out_valid = r_valid;
    assign result    = r_result;
    assign tag_out   = r_tag_out;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit (MUL_BPC=1 and MUL_BPC=4 instances).
module tb_muldiv_unit;

    localparam logic [2:0] F_MUL    = 3'd0;
    localparam logic [2:0] F_MULH   = 3'd1;
    localparam logic [2:0] F_MULHSU = 3'd2;
    localparam logic [2:0] F_MULHU  = 3'd3;
    localparam logic [2:0] F_DIV    = 3'd4;
    localparam logic [2:0] F_DIVU   = 3'd5;
    localparam logic [2:0] F_REM    = 3'd6;
    localparam logic [2:0] F_REMU   = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_valid4 = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rv1 = '0;
    logic [31:0] rv2 = '0;
    logic [4:0]  tag_in = '0;
    logic        out_ready = 1'b0;
    logic        out_ready4 = 1'b0;

    logic        in_ready, out_valid, busy;
    logic [31:0] result;
    logic [4:0]  tag_out;
    logic        in_ready4, out_valid4, busy4;
    logic [31:0] result4;
    logic [4:0]  tag_out4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .TAGW(5), .MUL_BPC(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .rv1(rv1), .rv2(rv2), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .tag_out(tag_out), .busy(busy)
    );

    muldiv_unit #(.XLEN(32), .TAGW(5), .MUL_BPC(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .funct3(funct3), .rv1(rv1), .rv2(rv2), .tag_in(tag_in),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .result(result4), .tag_out(tag_out4), .busy(busy4)
    );

    // Present one op for one edge; returns #1 after the accept edge.
    task automatic start_op(input bit sel4, input logic [2:0] f,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] t);
        funct3 = f; rv1 = a; rv2 = b; tag_in = t;
        if (sel4) in_valid4 = 1'b1; else in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_valid4 = 1'b0;
    endtask

    // Edges after the accept edge until out_valid is seen (capped at 200).
    task automatic wait_valid(input bit sel4, output int lat);
        lat = 0;
        while (!(sel4 ? out_valid4 : out_valid) && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take(input bit sel4);
        if (sel4) out_ready4 = 1'b1; else out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; out_ready4 = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] t,
                          output logic [31:0] res, output logic [4:0] tg,
                          output int lat);
        start_op(1'b0, f, a, b, t);
        wait_valid(1'b0, lat);
        res = result; tg = tag_out;
        take(1'b0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++;
            $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++;
        if (result !== 32'h0) begin errors++;
            $display("FAIL rst_result: got %h want 0", result); end
        checks++;
        if (tag_out !== 5'd0) begin errors++;
            $display("FAIL rst_tag_out: got %0d want 0", tag_out); end
        checks++;
        if (busy !== 1'b0) begin errors++;
            $display("FAIL rst_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++;
            $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_mul;
        logic [31:0] r; logic [4:0] t; int lat;
        run_op(F_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, r, t, lat);
        checks++;
        if (r !== 32'hFFFF_FFEB) begin errors++;
            $display("FAIL mul_res: got %h want ffffffeb", r); end
        checks++;
        if (t !== 5'd5) begin errors++;
            $display("FAIL mul_tag: got %0d want 5", t); end
        checks++;
        if (lat !== 32) begin errors++;
            $display("FAIL mul_latency: got %0d want 32", lat); end
        run_op(F_MULH, 32'h8000_0000, 32'h8000_0000, 5'd1, r, t, lat);
        checks++;
        if (r !== 32'h4000_0000) begin errors++;
            $display("FAIL mulh_res: got %h want 40000000", r); end
        run_op(F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, r, t, lat);
        checks++;
        if (r !== 32'hFFFF_FFFE) begin errors++;
            $display("FAIL mulhu_res: got %h want fffffffe", r); end
        run_op(F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, r, t, lat);
        checks++;
        if (r !== 32'hFFFF_FFFF) begin errors++;
            $display("FAIL mulhsu_res: got %h want ffffffff", r); end
    endtask

    task automatic test_div;
        logic [31:0] r; logic [4:0] t; int lat;
        run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, 5'd4, r, t, lat);
        checks++;
        if (r !== 32'hFFFF_FFFD) begin errors++;
            $display("FAIL div_res: got %h want fffffffd", r); end
        run_op(F_REM, 32'hFFFF_FFF9, 32'd2, 5'd6, r, t, lat);
        checks++;
        if (r !== 32'hFFFF_FFFF) begin errors++;
            $display("FAIL rem_res: got %h want ffffffff", r); end
        run_op(F_DIVU, 32'd100, 32'd7, 5'd11, r, t, lat);
        checks++;
        if (r !== 32'd14) begin errors++;
            $display("FAIL divu_res: got %0d want 14", r); end
        checks++;
        if (lat !== 32) begin errors++;
            $display("FAIL divu_latency: got %0d want 32", lat); end
        checks++;
        if (t !== 5'd11) begin errors++;
            $display("FAIL divu_tag: got %0d want 11", t); end
        run_op(F_REMU, 32'd100, 32'd7, 5'd12, r, t, lat);
        checks++;
        if (r !== 32'd2) begin errors++;
            $display("FAIL remu_res: got %0d want 2", r); end
    endtask

    task automatic test_special;
        logic [31:0] r; logic [4:0] t; int lat;
        run_op(F_DIVU, 32'd5, 32'd0, 5'd13, r, t, lat);
        checks++;
        if (r !== 32'hFFFF_FFFF) begin errors++;
            $display("FAIL divu0_res: got %h want ffffffff", r); end
        checks++;
        if (lat !== 0) begin errors++;
            $display("FAIL divu0_latency: got %0d want 0", lat); end
        checks++;
        if (t !== 5'd13) begin errors++;
            $display("FAIL divu0_tag: got %0d want 13", t); end
        run_op(F_REM, 32'd5, 32'd0, 5'd14, r, t, lat);
        checks++;
        if (r !== 32'd5) begin errors++;
            $display("FAIL rem0_res: got %h want 5", r); end
        run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, r, t, lat);
        checks++;
        if (r !== 32'h8000_0000 || lat !== 0) begin errors++;
            $display("FAIL div_ovf: got %h lat %0d want 80000000 lat 0", r, lat); end
        run_op(F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, r, t, lat);
        checks++;
        if (r !== 32'h0 || lat !== 0) begin errors++;
            $display("FAIL rem_ovf: got %h lat %0d want 0 lat 0", r, lat); end
    endtask

    task automatic test_flush;
        logic [31:0] r; logic [4:0] t; int lat; bit seen;
        start_op(1'b0, F_DIV, 32'd1000, 32'd3, 5'd9);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin errors++;
            $display("FAIL flush_in_ready_calc: got %b want 0", in_ready); end
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++;
            $display("FAIL flush_idle: busy %b out_valid %b want 0 0", busy, out_valid); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++;
            $display("FAIL flush_no_valid: got %b want 0", seen); end
        run_op(F_DIVU, 32'd100, 32'd7, 5'd10, r, t, lat);
        checks++;
        if (r !== 32'd14 || t !== 5'd10) begin errors++;
            $display("FAIL flush_next_op: got %0d tag %0d want 14 tag 10", r, t); end
        start_op(1'b0, F_MUL, 32'd3, 32'd3, 5'd7);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || result !== 32'h0 || tag_out !== 5'd0 || busy !== 1'b0)
        begin errors++;
            $display("FAIL reset_mid_calc: valid %b res %h tag %0d busy %b want all 0",
                     out_valid, result, tag_out, busy); end
    endtask

    task automatic test_hold;
        int lat;
        start_op(1'b0, F_MUL, 32'd7, 32'hFFFF_FFFD, 5'd3);
        wait_valid(1'b0, lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || result !== 32'hFFFF_FFEB || tag_out !== 5'd3
                || in_ready !== 1'b0) begin errors++;
                $display("FAIL hold_cycle%0d: valid %b res %h tag %0d in_ready %b",
                         i, out_valid, result, tag_out, in_ready); end
        end
        take(1'b0);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL hold_release: valid %b busy %b want 0 0", out_valid, busy); end
    endtask

    task automatic test_bpc4;
        int lat;
        start_op(1'b1, F_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5);
        wait_valid(1'b1, lat);
        checks++;
        if (lat !== 8) begin errors++;
            $display("FAIL bpc4_latency: got %0d want 8", lat); end
        checks++;
        if (result4 !== 32'hFFFF_FFEB || tag_out4 !== 5'd5) begin errors++;
            $display("FAIL bpc4_res: got %h tag %0d want ffffffeb tag 5", result4, tag_out4); end
        take(1'b1);
        start_op(1'b1, F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
        wait_valid(1'b1, lat);
        checks++;
        if (result4 !== 32'hFFFF_FFFE) begin errors++;
            $display("FAIL bpc4_mulhu: got %h want fffffffe", result4); end
        take(1'b1);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_flush();
        test_hold();
        test_bpc4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
